// File: rtl/maze_neighbor_sequencer.sv
// maze_neighbor_sequencer
// Walks the orthogonal neighbours (right, left, down, up) of a latched grid
// node, skips positions outside the grid, checks each remaining one against
// the wall map (one-cycle read latency) and streams open neighbours out over
// a valid/ready handshake. Ends with a one-cycle done pulse and the count of
// open neighbours.
// Optional feature macro: MAZE_NBR_DIAG_EN adds the four diagonal neighbours
// (down-right, down-left, up-right, up-left) after up.
module maze_neighbor_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int COL_BITS   = 4,
  parameter int GRID_H     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] current_node,
  output logic                  wall_req,
  output logic [DATA_WIDTH-1:0] wall_addr,
  input  logic                  wall_rdata,
  output logic                  nbr_valid,
  input  logic                  nbr_ready,
  output logic [DATA_WIDTH-1:0] nbr_node,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            nbr_count
);

  localparam int ROW_BITS = DATA_WIDTH - COL_BITS;
`ifdef MAZE_NBR_DIAG_EN
  localparam int NUM_CAND = 8;
`else
  localparam int NUM_CAND = 4;
`endif
  localparam logic [2:0]          LAST_IDX = 3'(NUM_CAND - 1);
  localparam logic [COL_BITS-1:0] COL_MAX  = '1;
  localparam logic [ROW_BITS-1:0] ROW_MAX  = ROW_BITS'(GRID_H - 1);
  localparam logic [ROW_BITS:0]   ROW_LIM  = (ROW_BITS + 1)'(GRID_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic [2:0]          idx_q;
  logic [3:0]          count_q;

  logic [ROW_BITS-1:0] cand_row;
  logic [COL_BITS-1:0] cand_col;
  logic                cand_ok;
  logic                start_oob;
  logic                last_cand;
  logic                advance;

  assign start_oob = {1'b0, current_node[DATA_WIDTH-1:COL_BITS]} >= ROW_LIM;
  assign last_cand = (idx_q == LAST_IDX);

  // Candidate position for the current index and whether it lies inside the grid
  always_comb begin
    cand_row = row_q;
    cand_col = col_q;
    cand_ok  = 1'b0;
    case (idx_q)
      3'd0: begin
        cand_col = col_q + COL_BITS'(1);
        cand_ok  = (col_q != COL_MAX);
      end
      3'd1: begin
        cand_col = col_q - COL_BITS'(1);
        cand_ok  = (col_q != '0);
      end
      3'd2: begin
        cand_row = row_q + ROW_BITS'(1);
        cand_ok  = (row_q != ROW_MAX);
      end
      3'd3: begin
        cand_row = row_q - ROW_BITS'(1);
        cand_ok  = (row_q != '0);
      end
`ifdef MAZE_NBR_DIAG_EN
      3'd4: begin
        cand_row = row_q + ROW_BITS'(1);
        cand_col = col_q + COL_BITS'(1);
        cand_ok  = (row_q != ROW_MAX) && (col_q != COL_MAX);
      end
      3'd5: begin
        cand_row = row_q + ROW_BITS'(1);
        cand_col = col_q - COL_BITS'(1);
        cand_ok  = (row_q != ROW_MAX) && (col_q != '0);
      end
      3'd6: begin
        cand_row = row_q - ROW_BITS'(1);
        cand_col = col_q + COL_BITS'(1);
        cand_ok  = (row_q != '0) && (col_q != COL_MAX);
      end
      3'd7: begin
        cand_row = row_q - ROW_BITS'(1);
        cand_col = col_q - COL_BITS'(1);
        cand_ok  = (row_q != '0) && (col_q != '0);
      end
`endif
      default: cand_ok = 1'b0;
    endcase
  end

  // A candidate is finished when it is out of grid, blocked, or handed off
  always_comb begin
    advance = 1'b0;
    case (state)
      S_CHECK: advance = !cand_ok;
      S_WAIT:  advance = wall_rdata;
      S_EMIT:  advance = nbr_ready;
      default: advance = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = start_oob ? S_DONE : S_CHECK;
      S_CHECK: if (cand_ok) state_nxt = S_WAIT;
               else         state_nxt = last_cand ? S_DONE : S_CHECK;
      S_WAIT:  if (wall_rdata) state_nxt = last_cand ? S_DONE : S_CHECK;
               else            state_nxt = S_EMIT;
      S_EMIT:  if (nbr_ready) state_nxt = last_cand ? S_DONE : S_CHECK;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latched node, candidate index and open-neighbour count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        row_q   <= current_node[DATA_WIDTH-1:COL_BITS];
        col_q   <= current_node[COL_BITS-1:0];
        idx_q   <= '0;
        count_q <= '0;
      end
    end else begin
      if (advance && !last_cand) idx_q <= idx_q + 3'd1;
      if (state == S_EMIT && nbr_ready) count_q <= count_q + 4'd1;
    end
  end

  // Outputs decoded from state; address/data buses forced to zero when not strobed
  always_comb begin
    wall_req  = 1'b0;
    wall_addr = '0;
    nbr_valid = 1'b0;
    nbr_node  = '0;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    nbr_count = count_q;
    if (state == S_CHECK && cand_ok) begin
      wall_req  = 1'b1;
      wall_addr = {cand_row, cand_col};
    end
    if (state == S_EMIT) begin
      nbr_valid = 1'b1;
      nbr_node  = {cand_row, cand_col};
    end
  end

endmodule

// File: tb/tb_maze_neighbor_sequencer.sv
// Bench for maze_neighbor_sequencer: directed scenarios plus randomized
// nodes, walls and backpressure, checked against a neighbour-list model.
module tb_maze_neighbor_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] current_node = '0;
  logic       wall_req;
  logic [7:0] wall_addr;
  logic       wall_rdata = 1'b0;
  logic       nbr_valid;
  logic       nbr_ready = 1'b1;
  logic [7:0] nbr_node;
  logic       busy;
  logic       done;
  logic [3:0] nbr_count;

  maze_neighbor_sequencer #(.DATA_WIDTH(8), .COL_BITS(4), .GRID_H(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .current_node(current_node),
    .wall_req(wall_req), .wall_addr(wall_addr), .wall_rdata(wall_rdata),
    .nbr_valid(nbr_valid), .nbr_ready(nbr_ready), .nbr_node(nbr_node),
    .busy(busy), .done(done), .nbr_count(nbr_count)
  );

  always #5 clk = ~clk;

`ifdef MAZE_NBR_DIAG_EN
  localparam int NC = 8;
`else
  localparam int NC = 4;
`endif

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: neighbour list from grid geometry and the wall map
  logic wall_map [256];
  int   exp_q[$];
  int   exp_e[$];
  int   exp_count;
  int   exp_base;

  function automatic void model(input logic [7:0] n);
    int dr[8] = '{0, 0, 1, -1, 1, 1, -1, -1};
    int dc[8] = '{1, -1, 0, 0, 1, -1, 1, -1};
    int r, c, nr, nc, a;
    exp_q.delete();
    exp_e.delete();
    exp_base = 0;
    r = int'(n[7:4]);
    c = int'(n[3:0]);
    for (int i = 0; i < NC; i++) begin
      nr = r + dr[i];
      nc = c + dc[i];
      if (nr < 0 || nr > 15 || nc < 0 || nc > 15) begin
        exp_base += 1;
      end else begin
        a = nr * 16 + nc;
        exp_q.push_back(a);
        if (wall_map[a]) exp_base += 2;
        else begin
          exp_base += 3;
          exp_e.push_back(a);
        end
      end
    end
    exp_count = exp_e.size();
  endfunction

  task automatic clear_walls();
    for (int i = 0; i < 256; i++) wall_map[i] = 1'b0;
  endtask

  // Wall memory: one-cycle read latency, junk when not strobed
  always @(posedge clk) wall_rdata <= wall_req ? wall_map[wall_addr] : 1'($urandom);

  // Consumer ready: 0 = always, 1 = random, 2 = low for stall_left valid cycles
  int ready_mode = 0;
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: nbr_ready = 1'b1;
      1: nbr_ready = ($urandom % 3) != 0;
      default: begin
        nbr_ready = !(nbr_valid && stall_left > 0);
        if (nbr_valid && stall_left > 0) stall_left--;
      end
    endcase
  end

  // Monitor state
  bit   active = 1'b0;
  bit   done_seen = 1'b0;
  bit   prev_hold = 1'b0;
  logic [7:0] prev_node = '0;
  int   busy_cyc, stalls, nq;
  int   log_e[$];

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (!wall_req)  chk("wall_addr_zero", wall_addr, 0);
      if (!nbr_valid) chk("nbr_node_zero", nbr_node, 0);
      if (prev_hold) begin
        chk("nbr_valid_hold", nbr_valid, 1);
        chk("nbr_node_hold", nbr_node, prev_node);
      end
      prev_hold = nbr_valid && !nbr_ready;
      prev_node = nbr_node;
      if (active) begin
        if (busy && !done) busy_cyc++;
        if (wall_req) begin
          nq++;
          if (exp_q.size() == 0) chk("wall_req_extra", 1, 0);
          else chk("wall_addr", wall_addr, exp_q.pop_front());
        end
        if (nbr_valid && !nbr_ready) stalls++;
        if (nbr_valid && nbr_ready) begin
          log_e.push_back(int'(nbr_node));
          if (exp_e.size() == 0) chk("nbr_extra", 1, 0);
          else chk("nbr_node", nbr_node, exp_e.pop_front());
        end
        if (done) begin
          chk("nbr_count", nbr_count, exp_count);
          chk("busy_with_done", busy, 1);
          chk("cycles", busy_cyc, exp_base + stalls);
          chk("queries_left", exp_q.size(), 0);
          chk("emits_left", exp_e.size(), 0);
          done_seen = 1'b1;
          active = 1'b0;
        end
      end
    end
  end

  task automatic run(input logic [7:0] n, input int inject_at);
    model(n);
    busy_cyc = 0; stalls = 0; nq = 0; done_seen = 1'b0;
    log_e.delete();
    @(posedge clk); #1;
    start = 1'b1; current_node = n; active = 1'b1;
    @(negedge clk);
    chk("busy_before_start", busy, 0);
    @(posedge clk); #1;
    start = 1'b0; current_node = 8'($urandom);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 300 && !done_seen; i++) begin
      @(posedge clk); #1;
      start = (i == inject_at);
      current_node = start ? 8'h22 : 8'($urandom);
    end
    start = 1'b0;
    if (!done_seen) begin
      chk("done_timeout", 0, 1);
      active = 1'b0;
    end
    chk("busy_after_done", busy, 0);
    chk("count_held", nbr_count, exp_count);
  endtask

  task automatic chk_log(input string name, input int want[$]);
    chk({name, "_len"}, log_e.size(), want.size());
    for (int i = 0; i < want.size() && i < log_e.size(); i++)
      chk(name, log_e[i], want[i]);
  endtask

  initial begin
    int want[$];
    int wait_cnt;
    clear_walls();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {wall_req, wall_addr, nbr_valid, nbr_node, busy, done, nbr_count}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Corner node, everything free
    run(8'h00, -1);
    want = '{32'h01, 32'h10};
    chk_log("log_00", want);
    chk("busy_cycles_00", busy_cyc, 8);
    chk("count_00", nbr_count, 2);

    // Centre node, everything free
    run(8'h55, -1);
`ifdef MAZE_NBR_DIAG_EN
    want = '{32'h56, 32'h54, 32'h65, 32'h45, 32'h66, 32'h64, 32'h46, 32'h44};
    chk_log("log_55", want);
    chk("count_55", nbr_count, 8);
    chk("wall_req_55", nq, 8);
`else
    want = '{32'h56, 32'h54, 32'h65, 32'h45};
    chk_log("log_55", want);
    chk("count_55", nbr_count, 4);
    chk("wall_req_55", nq, 4);
`endif

    // Start pulsed mid-expansion must not disturb anything
    run(8'h55, 3);
    chk_log("log_55_inject", want);

    // Walls on two of the neighbours
    wall_map[8'h56] = 1'b1;
    wall_map[8'h45] = 1'b1;
    run(8'h55, -1);
`ifndef MAZE_NBR_DIAG_EN
    want = '{32'h54, 32'h65};
    chk_log("log_55_walls", want);
    chk("count_55_walls", nbr_count, 2);
`endif
    clear_walls();

    // Far corner with five cycles of backpressure on the first emit
    ready_mode = 2; stall_left = 5;
    run(8'hFF, -1);
    chk("stalls_ff", stalls, 5);
`ifndef MAZE_NBR_DIAG_EN
    want = '{32'hFE, 32'hEF};
    chk_log("log_ff", want);
    chk("count_ff", nbr_count, 2);
`endif

    // Reset while holding a neighbour in EMIT
    stall_left = 50;
    model(8'h55);
    @(posedge clk); #1 start = 1'b1; current_node = 8'h55;
    @(posedge clk); #1 start = 1'b0;
    wait_cnt = 0;
    while (!nbr_valid && wait_cnt < 50) begin
      @(posedge clk); #2;
      wait_cnt++;
    end
    chk("emit_reached", nbr_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_emit", {wall_req, wall_addr, nbr_valid, nbr_node, busy, done, nbr_count}, 0);
    ready_mode = 0; stall_left = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    run(8'h00, -1);
    want = '{32'h01, 32'h10};
    chk_log("log_00_after_reset", want);
    chk("busy_cycles_00_after_reset", busy_cyc, 8);

    // Randomized nodes, walls and backpressure
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 256; i++) wall_map[i] = ($urandom % 10) < 3;
      ready_mode = int'($urandom % 2);
      run(8'($urandom), ($urandom % 2) ? int'($urandom % 4) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maze_neighbor_sequencer.md
# maze_neighbor_sequencer

- Sequences neighbour expansion for the A* maze search.
- On `start`, latches the current grid node and walks its candidate neighbours in a fixed order: right, left, down, up.
- For each candidate it discards out-of-grid positions, queries the wall map through a one-cycle-latency read port, and streams each open neighbour to the open-list logic over a valid/ready handshake.
- Pulses `done` with the neighbour count when all candidates have been processed.

## Interface
Parameters:
- `DATA_WIDTH`, 8 — node index width; node = {row, col}.
- `COL_BITS`, 4 — column field width; grid width GRID_W = 2^COL_BITS.
- `GRID_H`, 16 — number of rows; GRID_H ≤ 2^(DATA_WIDTH−COL_BITS).

Ports:
- `clk`  in  1  — sole clock; all state changes on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — begin expansion; accepted only in IDLE.
- `current_node`  in  DATA_WIDTH  — node to expand; latched when `start` is accepted.
- `wall_req`  out  1  — wall-map read strobe.
- `wall_addr`  out  DATA_WIDTH  — candidate node being queried.
- `wall_rdata`  in  1  — wall bit (1 = blocked); valid the cycle after `wall_req`.
- `nbr_valid`  out  1  — `nbr_node` holds an open neighbour.
- `nbr_ready`  in  1  — consumer accepts `nbr_node`.
- `nbr_node`  out  DATA_WIDTH  — neighbour index.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — single-cycle pulse at the end of expansion.
- `nbr_count`  out  4  — open neighbours emitted; valid while `done` is high, held until the next start.

## Operation
- FSM states:
  - IDLE:
    - `start` → latch node, clear count, index = 0, go to CHECK.
    - If the latched row ≥ GRID_H, go directly to DONE with count 0.
  - CHECK:
    - Candidate out of grid → advance index, no `wall_req`.
    - Otherwise assert `wall_req` with `wall_addr` = candidate and go to WAIT.
  - WAIT:
    - Sample `wall_rdata`.
    - 0 → EMIT.
    - 1 → advance.
  - EMIT:
    - Hold `nbr_valid` = 1 with `nbr_node` stable until `nbr_valid & nbr_ready`.
    - On transfer, increment count and advance.
  - Advance:
    - After the last candidate → DONE.
    - Otherwise → CHECK with index + 1.
  - DONE: `done` = 1 for one cycle, then IDLE.
- Candidate generation (row r, column c):
  - right {r, c+1}, valid if c ≠ GRID_W−1.
  - left {r, c−1}, valid if c ≠ 0.
  - down {r+1, c}, valid if r ≠ GRID_H−1.
  - up {r−1, c}, valid if r ≠ 0.
- Arithmetic is per field; wrap-around is never emitted.
- `start` while busy is ignored; the current expansion is unaffected.
- `current_node` changes after acceptance have no effect.
- `wall_addr` is 0 whenever `wall_req` = 0.
- `nbr_node` is 0 whenever `nbr_valid` = 0.

## Timing
- Reset values:
  - State IDLE.
  - `wall_req`, `nbr_valid`, `busy`, `done` = 0.
  - `wall_addr`, `nbr_node`, `nbr_count` = 0.
- Reset mid-operation aborts immediately; there is no partial `done`.
- `start` sampled at edge k → `busy` = 1 from k+1.
- Per-candidate cost with `nbr_ready` held high:
  - Out-of-grid: 1 cycle.
  - Blocked: 2 cycles.
  - Open: 3 cycles.
  - Each cycle of backpressure adds 1 cycle.
- `done` is asserted in the cycle after the final candidate completes; `busy` falls together with `done`.
- `start` is accepted again the cycle after `done` (IDLE).
- `nbr_valid` never deasserts without a transfer.

## Configuration
- `MAZE_NBR_DIAG_EN` defined:
  - Four extra candidates are appended after up, in the order down-right, down-left, up-right, up-left.
  - Each diagonal is valid only if both its row and column offsets stay in the grid.
  - The index runs 0–7 and `nbr_count` reaches up to 8.
- Undefined: only the four orthogonal candidates exist and the count maximum is 4.

## Test plan
All scenarios use default parameters.
- Node 0x00, all walls 0, ready high → emits 0x01 then 0x10; `done` 8 cycles after `busy` rises; count = 2.
- Node 0x55, all free → emits 0x56, 0x54, 0x65, 0x45 in order; count = 4; `wall_req` pulses 4 times.
- Node 0x55, wall at 0x56 and 0x45 → emits 0x54, 0x65; count = 2.
- Node 0xFF, ready low for 5 cycles at the first emit → 0xFE is held stable for 5 cycles; then 0xEF is emitted; count = 2.
- `start` with node 0x22 pulsed mid-expansion of 0x55 → ignored; outputs are identical to the 0x55 run.
- Reset asserted during EMIT → all outputs 0 immediately; a subsequent start on 0x00 produces the nominal result.
- With `MAZE_NBR_DIAG_EN`, node 0x55 all free → eight neighbours, ending 0x66, 0x64, 0x46, 0x44; count = 8.
